// File: rtl/uart_rx.sv
// uart_rx: UART receiver with a show-ahead byte FIFO.
//
// Receives 8N1 frames from a host TXD line. With the macro UART_RX_PARITY_EN
// defined, it receives 8E1 frames instead. Received bytes are buffered in a
// 2^FIFO_ASIZE-entry FIFO and presented on a valid/ready interface.
//
// Parameters
//   UART_CLK_DIV : one bit period is 2*UART_CLK_DIV clk cycles (>= 2)
//   FIFO_ASIZE   : FIFO depth is 2^FIFO_ASIZE bytes (1..16)
//
// Ports
//   clk        : system clock
//   rst        : synchronous reset, active-high
//   i_uart_rx  : serial input, idle high, asynchronous to clk
//   rvalid     : FIFO non-empty; rdata holds the oldest byte
//   rready     : consumer accepts rdata when rvalid && rready
//   rdata      : oldest received byte (show-ahead)
//   frame_err  : one-cycle pulse on bad stop bit (or parity mismatch)
//   overflow   : one-cycle pulse when a received byte is dropped on a full FIFO
//   fifo_count : number of bytes currently stored

module uart_rx #(
    parameter int unsigned UART_CLK_DIV = 434,
    parameter int unsigned FIFO_ASIZE   = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_uart_rx,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [7:0]            rdata,
    output logic                  frame_err,
    output logic                  overflow,
    output logic [FIFO_ASIZE:0]   fifo_count
);

    localparam int unsigned BP    = 2 * UART_CLK_DIV;
    localparam int unsigned CW    = $clog2(BP);
    localparam int unsigned AW    = FIFO_ASIZE;
    localparam int unsigned PW    = FIFO_ASIZE + 1;
    localparam int unsigned DEPTH = 1 << FIFO_ASIZE;

    localparam logic [CW-1:0] CNT_HALF = CW'(BP / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_e;

    // ------------------------------------------------------------------
    // Two-flop synchroniser; both flops reset to the idle (high) level.
    // ------------------------------------------------------------------
    logic sync1_q;
    logic rx_s_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= i_uart_rx;
            rx_s_q  <= sync1_q;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM with its bit-period counter and registered strobes.
    // ------------------------------------------------------------------
    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic            push_q;
    logic            frame_err_q;
`ifdef UART_RX_PARITY_EN
    logic            par_err_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
            cnt_q       <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);

            unique case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (!rx_s_q) begin
                        state_q <= S_START;
                    end
                end

                // Re-check half a bit in: a high line means the edge was a glitch.
                S_START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
`ifdef UART_RX_PARITY_EN
                        par_err_q <= 1'b0;
`endif
                        state_q   <= rx_s_q ? S_IDLE : S_DATA;
                    end
                end

                S_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q              <= '0;
                        shift_q[bit_idx_q] <= rx_s_q;
                        bit_idx_q          <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                // Even parity: data bits xor parity bit must be zero.
                S_PARITY: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q     <= '0;
                        par_err_q <= (^shift_q) ^ rx_s_q;
                        state_q   <= S_STOP;
                    end
                end
`endif

                // Leave half a bit early so a back-to-back start edge is not missed.
                S_STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (rx_s_q) begin
`ifdef UART_RX_PARITY_EN
                            push_q      <= !par_err_q;
                            frame_err_q <= par_err_q;
`else
                            push_q      <= 1'b1;
`endif
                            state_q     <= S_IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_BREAK;
                        end
                    end
                end

                // Held-low line: wait for it to return high before hunting again.
                S_BREAK: begin
                    if (rx_s_q) begin
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointer/count arithmetic and show-ahead head selection.
    // ------------------------------------------------------------------
    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_d;
    logic [PW-1:0] rd_ptr_d;
    logic [PW-1:0] count_d;
    logic [PW-1:0] count_q;
    logic          rvalid_q;
    logic [7:0]    rdata_q;
    logic [7:0]    rdata_d;
    logic          overflow_q;
    logic          full_c;
    logic          pop_c;
    logic          push_ok_c;

    always_comb begin
        full_c    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop_c     = rvalid_q && rready;
        // A pop in the same cycle frees the slot for a push into a full FIFO.
        push_ok_c = push_q && (!full_c || pop_c);
        wr_ptr_d  = wr_ptr_q + PW'(push_ok_c);
        rd_ptr_d  = rd_ptr_q + PW'(pop_c);
        count_d   = wr_ptr_d - rd_ptr_d;
        rdata_d   = rdata_q;
        if (count_d != '0) begin
            // Byte being written becomes the head only when the FIFO drains to it.
            if (push_ok_c && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
                rdata_d = shift_q;
            end else begin
                rdata_d = mem_q[rd_ptr_d[AW-1:0]];
            end
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
        end
    end

    // FIFO control state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rvalid_q   <= (count_d != '0);
            rdata_q    <= rdata_d;
            overflow_q <= push_q && full_c && !pop_c;
        end
    end

    assign rvalid     = rvalid_q;
    assign rdata      = rdata_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx with BP=8 clk cycles and a 4-deep FIFO.
// Clock period is 100 time units, so one exact bit time is 800 units.

module tb_uart_rx;

    localparam int BT = 800;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    // Offset from a frame's start edge to the clk edge that samples the stop bit.
    localparam int STOP_OFS = 610 + BT * (FRAME_BITS - 1);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rready = 1'b0;
    logic       rvalid;
    logic [7:0] rdata;
    logic       frame_err;
    logic       overflow;
    logic [2:0] fifo_count;
`ifdef UART_RX_PARITY_EN
    logic       par_flip = 1'b0;
`endif

    int total = 0;
    int bad = 0;
    int fe_cycles = 0;
    int ovf_cycles = 0;
    logic [7:0] got[$];

    uart_rx #(.UART_CLK_DIV(4), .FIFO_ASIZE(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_uart_rx (rx),
        .rvalid    (rvalid),
        .rready    (rready),
        .rdata     (rdata),
        .frame_err (frame_err),
        .overflow  (overflow),
        .fifo_count(fifo_count)
    );

    always #50 clk = ~clk;

    // Record accepted bytes and error pulses away from the active edge.
    always @(negedge clk) begin
        if (rvalid && rready) got.push_back(rdata);
        if (frame_err) fe_cycles++;
        if (overflow) ovf_cycles++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Start edge lands 10 units before a rising clk edge.
    task automatic align();
        @(posedge clk);
        #90;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int bt);
        rx = 1'b0;
        #(bt);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            #(bt);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^d) ^ par_flip;
        #(bt);
`endif
        rx = stop_bit;
        #(bt);
        rx = 1'b1;
    endtask

    task automatic pop_until(input int target);
        int n;
        n = 0;
        @(posedge clk);
        #20;
        rready = 1'b1;
        while (got.size() < target && n < 200) begin
            @(posedge clk);
            #20;
            n++;
        end
        rready = 1'b0;
        if (got.size() < target) begin
            total++; bad++;
            $display("FAIL pop_timeout got=%0d want=%0d", got.size(), target);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%b want=0", rvalid); end
        total++; if (rdata !== 8'h00) begin bad++; $display("FAIL rst_rdata got=%h want=00", rdata); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL rst_frame_err got=%b want=0", frame_err); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow got=%b want=0", overflow); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", fifo_count); end
        @(posedge clk);
        #20;
        rst = 1'b0;
        repeat (20) @(posedge clk);
    endtask

    task automatic test_single();
        int b, fe0, ov0;
        b = got.size(); fe0 = fe_cycles; ov0 = ovf_cycles;
        @(posedge clk);
        #20;
        rready = 1'b1;
        align();
        send_frame(8'h55, 1'b1, BT);
        repeat (10) @(posedge clk);
        #20;
        rready = 1'b0;
        @(negedge clk);
        total++; if (got.size() !== b + 1) begin bad++; $display("FAIL single_count got=%0d want=%0d", got.size(), b + 1); end
        total++; if (got.size() > b && got[b] !== 8'h55) begin bad++; $display("FAIL single_data got=%h want=55", got[b]); end
        total++; if (fe_cycles - fe0 !== 0) begin bad++; $display("FAIL single_frame_err got=%0d want=0", fe_cycles - fe0); end
        total++; if (ovf_cycles - ov0 !== 0) begin bad++; $display("FAIL single_overflow got=%0d want=0", ovf_cycles - ov0); end
        total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL single_rvalid_after got=%b want=0", rvalid); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL single_fifo_count got=%0d want=0", fifo_count); end
    endtask

    task automatic test_back_to_back();
        int fe0;
        fe0 = fe_cycles;
        align();
        send_frame(8'hA5, 1'b1, BT);
        send_frame(8'h00, 1'b1, BT);
        send_frame(8'hFF, 1'b1, BT);
        send_frame(8'h3C, 1'b1, BT);
        repeat (10) @(posedge clk);
        @(negedge clk);
        total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL b2b_count got=%0d want=4", fifo_count); end
        total++; if (rvalid !== 1'b1) begin bad++; $display("FAIL b2b_rvalid got=%b want=1", rvalid); end
        total++; if (rdata !== 8'hA5) begin bad++; $display("FAIL b2b_head got=%h want=a5", rdata); end
        total++; if (fe_cycles - fe0 !== 0) begin bad++; $display("FAIL b2b_frame_err got=%0d want=0", fe_cycles - fe0); end
    endtask

    task automatic test_overflow();
        int b, ov0;
        b = got.size(); ov0 = ovf_cycles;
        align();
        send_frame(8'h77, 1'b1, BT);
        repeat (10) @(posedge clk);
        @(negedge clk);
        total++; if (ovf_cycles - ov0 !== 1) begin bad++; $display("FAIL ovf_pulse_cycles got=%0d want=1", ovf_cycles - ov0); end
        total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL ovf_count got=%0d want=4", fifo_count); end
        total++; if (rdata !== 8'hA5) begin bad++; $display("FAIL ovf_head got=%h want=a5", rdata); end
        total++; if (got.size() !== b) begin bad++; $display("FAIL ovf_no_pop got=%0d want=%0d", got.size(), b); end
    endtask

    // Pop one byte on the stop-sample edge of a frame arriving into a full FIFO.
    task automatic test_full_pop();
        int b, ov0;
        logic [7:0] exp_q [4];
        exp_q[0] = 8'h00; exp_q[1] = 8'hFF; exp_q[2] = 8'h3C; exp_q[3] = 8'h77;
        b = got.size(); ov0 = ovf_cycles;
        align();
        fork
            send_frame(8'h77, 1'b1, BT);
            begin
                #(STOP_OFS - 70);
                rready = 1'b1;
                #90;
                rready = 1'b0;
            end
        join
        repeat (10) @(posedge clk);
        @(negedge clk);
        total++; if (ovf_cycles - ov0 !== 0) begin bad++; $display("FAIL fullpop_overflow got=%0d want=0", ovf_cycles - ov0); end
        total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL fullpop_count got=%0d want=4", fifo_count); end
        total++; if (got.size() !== b + 1) begin bad++; $display("FAIL fullpop_pops got=%0d want=%0d", got.size(), b + 1); end
        total++; if (got.size() > b && got[b] !== 8'hA5) begin bad++; $display("FAIL fullpop_first got=%h want=a5", got[b]); end
        pop_until(b + 5);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (got.size() > b + 1 + i && got[b + 1 + i] !== exp_q[i]) begin
                bad++; $display("FAIL drain_byte%0d got=%h want=%h", i, got[b + 1 + i], exp_q[i]);
            end
        end
        @(negedge clk);
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL drain_count got=%0d want=0", fifo_count); end
        total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL drain_rvalid got=%b want=0", rvalid); end
    endtask

    task automatic test_glitch();
        int fe0;
        fe0 = fe_cycles;
        align();
        rx = 1'b0;
        #200;
        rx = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL glitch_count got=%0d want=0", fifo_count); end
        total++; if (fe_cycles - fe0 !== 0) begin bad++; $display("FAIL glitch_frame_err got=%0d want=0", fe_cycles - fe0); end
    endtask

    task automatic test_bad_stop();
        int fe0;
        fe0 = fe_cycles;
        align();
        send_frame(8'h5A, 1'b0, BT);
        repeat (20) @(posedge clk);
        @(negedge clk);
        total++; if (fe_cycles - fe0 !== 1) begin bad++; $display("FAIL badstop_frame_err got=%0d want=1", fe_cycles - fe0); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL badstop_count got=%0d want=0", fifo_count); end
    endtask

    // Line held low well past a full frame, then a good frame.
    task automatic test_break();
        int fe0, b;
        fe0 = fe_cycles;
        align();
        rx = 1'b0;
        #(12 * BT);
        rx = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        total++; if (fe_cycles - fe0 !== 1) begin bad++; $display("FAIL break_frame_err got=%0d want=1", fe_cycles - fe0); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL break_count got=%0d want=0", fifo_count); end
        b = got.size();
        @(posedge clk);
        #20;
        rready = 1'b1;
        align();
        send_frame(8'h12, 1'b1, BT);
        repeat (10) @(posedge clk);
        #20;
        rready = 1'b0;
        @(negedge clk);
        total++; if (got.size() !== b + 1) begin bad++; $display("FAIL after_break_count got=%0d want=%0d", got.size(), b + 1); end
        total++; if (got.size() > b && got[b] !== 8'h12) begin bad++; $display("FAIL after_break_data got=%h want=12", got[b]); end
    endtask

    task automatic test_reset_midframe();
        int fe0;
        fe0 = fe_cycles;
        align();
        rx = 1'b0;
        #(3 * BT);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (rdata !== 8'h00) begin bad++; $display("FAIL midrst_rdata got=%h want=00", rdata); end
        @(posedge clk);
        #20;
        rx = 1'b1;
        rst = 1'b0;
        repeat (12 * 8) @(posedge clk);
        @(negedge clk);
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL midrst_count got=%0d want=0", fifo_count); end
        total++; if (fe_cycles - fe0 !== 0) begin bad++; $display("FAIL midrst_frame_err got=%0d want=0", fe_cycles - fe0); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int b, fe0;
        b = got.size(); fe0 = fe_cycles;
        @(posedge clk);
        #20;
        rready = 1'b1;
        align();
        par_flip = 1'b0;
        send_frame(8'h03, 1'b1, BT);
        repeat (5) @(posedge clk);
        align();
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1, BT);
        par_flip = 1'b0;
        repeat (10) @(posedge clk);
        #20;
        rready = 1'b0;
        @(negedge clk);
        total++; if (got.size() !== b + 1) begin bad++; $display("FAIL parity_count got=%0d want=%0d", got.size(), b + 1); end
        total++; if (got.size() > b && got[b] !== 8'h03) begin bad++; $display("FAIL parity_data got=%h want=03", got[b]); end
        total++; if (fe_cycles - fe0 !== 1) begin bad++; $display("FAIL parity_frame_err got=%0d want=1", fe_cycles - fe0); end
    endtask
`endif

    // Bit time 4% short (768) and 4% long (832).
    task automatic test_stretch();
        int b, fe0;
        logic [7:0] d [4];
        int bt [4];
        d[0] = 8'hC3; d[1] = 8'h96; d[2] = 8'h01; d[3] = 8'h80;
        bt[0] = 768;  bt[1] = 832;  bt[2] = 768;  bt[3] = 832;
        b = got.size(); fe0 = fe_cycles;
        @(posedge clk);
        #20;
        rready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            align();
            send_frame(d[i], 1'b1, bt[i]);
            repeat (5) @(posedge clk);
        end
        repeat (10) @(posedge clk);
        #20;
        rready = 1'b0;
        @(negedge clk);
        total++; if (got.size() !== b + 4) begin bad++; $display("FAIL stretch_count got=%0d want=%0d", got.size(), b + 4); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (got.size() > b + i && got[b + i] !== d[i]) begin
                bad++; $display("FAIL stretch_byte%0d got=%h want=%h", i, got[b + i], d[i]);
            end
        end
        total++; if (fe_cycles - fe0 !== 0) begin bad++; $display("FAIL stretch_frame_err got=%0d want=0", fe_cycles - fe0); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_pop();
        test_glitch();
        test_bad_stop();
        test_break();
        test_reset_midframe();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_stretch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
